// File: rtl/tmds_pkg.sv
// Shared definitions for the TMDS channel decoder.
// Holds the symbol and byte widths, the four control-token codes, the
// alignment state enum and a small popcount helper.
package tmds_pkg;

  localparam int unsigned SymW  = 10;
  localparam int unsigned ByteW = 8;

  // Control-period tokens, indexed by {C1,C0}
  localparam logic [SymW-1:0] CtrlTok00 = 10'b1101010100;
  localparam logic [SymW-1:0] CtrlTok01 = 10'b0010101011;
  localparam logic [SymW-1:0] CtrlTok10 = 10'b0101010100;
  localparam logic [SymW-1:0] CtrlTok11 = 10'b1010101011;

  typedef enum logic [1:0] {
    SEARCH,
    SLIP,
    LOCKED
  } tmds_state_e;

  function automatic logic [3:0] popcount8(input logic [ByteW-1:0] b);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < ByteW; i++) begin
      n = n + {3'b000, b[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/tmds_symbol_decode.sv
// Combinational classify/decode/check of one word-aligned TMDS symbol.
// Ports:
//   sym_i      received 10-bit symbol ({inv, xor_flag, payload[7:0]})
//   is_ctrl_o  symbol is one of the four control tokens
//   ctrl_o     {C1,C0} of the token (0 for data)
//   data_o     recovered byte (don't-care for tokens)
//   err_o      data symbol whose XOR/XNOR flag contradicts the encoder's rule
module tmds_symbol_decode
  import tmds_pkg::*;
(
  input  logic [SymW-1:0]  sym_i,
  output logic             is_ctrl_o,
  output logic [1:0]       ctrl_o,
  output logic [ByteW-1:0] data_o,
  output logic             err_o
);

  logic [ByteW-1:0] d;
  logic [ByteW-1:0] data;
  logic [3:0]       ones;
  logic             want_xnor;

  always_comb begin
    is_ctrl_o = 1'b1;
    ctrl_o    = 2'b00;
    unique case (sym_i)
      CtrlTok00: ctrl_o = 2'b00;
      CtrlTok01: ctrl_o = 2'b01;
      CtrlTok10: ctrl_o = 2'b10;
      CtrlTok11: ctrl_o = 2'b11;
      default:   is_ctrl_o = 1'b0;
    endcase
  end

  always_comb begin
    // Undo DC-balance inversion, then the transition-minimisation chain
    d       = sym_i[9] ? ~sym_i[7:0] : sym_i[7:0];
    data    = '0;
    data[0] = d[0];
    for (int i = 1; i < ByteW; i++) begin
      data[i] = sym_i[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
    end
  end

  always_comb begin
    ones      = popcount8(data);
    // Re-derive the encoder's XNOR choice from the recovered byte
    want_xnor = (ones > 4'd4) || ((ones == 4'd4) && !data[0]);
    // XNOR is signalled by flag 0, so equality means a mismatch
    err_o     = !is_ctrl_o && (want_xnor == sym_i[8]);
  end

  assign data_o = data;

endmodule

// File: rtl/tmds_channel_decoder.sv
// Receive-side decoder for one TMDS channel.
// Two-stage pipeline (input register, decode register) with a word-alignment
// state machine that requests bit slips until a run of control tokens is seen,
// then stays locked until too many errored data symbols arrive.
// Ports:
//   clk, n_rst   clock, asynchronous active-low reset
//   sym_in       word-aligned symbol from the deserializer, sym_valid qualifies
//   data_out     decoded byte (de_out=1), ctrl_out {C1,C0} (de_out=0)
//   out_valid    stage-2 valid while locked
//   err_out      errored data symbol, aligned with the other outputs
//   locked       alignment state machine is locked
//   bitslip      one-cycle request to shift deserializer alignment
module tmds_channel_decoder
  import tmds_pkg::*;
#(
  parameter int unsigned LOCK_COUNT   = 8,
  parameter int unsigned SEARCH_LIMIT = 64,
  parameter int unsigned SLIP_WAIT    = 4,
  parameter int unsigned ERR_LIMIT    = 4
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic [SymW-1:0]  sym_in,
  input  logic             sym_valid,
  output logic [ByteW-1:0] data_out,
  output logic [1:0]       ctrl_out,
  output logic             de_out,
  output logic             out_valid,
  output logic             err_out,
  output logic             locked,
  output logic             bitslip
);

  localparam int unsigned RunW  = $clog2(LOCK_COUNT + 1);
  localparam int unsigned SrchW = $clog2(SEARCH_LIMIT + 1);
  localparam int unsigned SlipW = $clog2(SLIP_WAIT + 1);
  localparam int unsigned ErrW  = $clog2(ERR_LIMIT + 1);

  localparam logic [RunW-1:0]  RunMax  = RunW'(LOCK_COUNT);
  localparam logic [SrchW-1:0] SrchMax = SrchW'(SEARCH_LIMIT);
  localparam logic [SlipW-1:0] SlipMax = SlipW'(SLIP_WAIT);
  localparam logic [ErrW-1:0]  ErrMax  = ErrW'(ERR_LIMIT);

  // Stage 1
  logic [SymW-1:0]  s1_sym_q;
  logic             s1_valid_q;

  // Stage 2
  logic [ByteW-1:0] data_q,     data_d;
  logic [1:0]       ctrl_q,     ctrl_d;
  logic             de_q,       de_d;
  logic             err_q,      err_d;
  logic             s2_valid_q, s2_valid_d;

  // Alignment FSM
  tmds_state_e      state_q,    state_d;
  logic [RunW-1:0]  run_q,      run_d;
  logic [SrchW-1:0] srch_q,     srch_d;
  logic [SlipW-1:0] slip_q,     slip_d;
  logic [ErrW-1:0]  errc_q,     errc_d;
  logic             bitslip_q,  bitslip_d;

  logic             dec_is_ctrl;
  logic [1:0]       dec_ctrl;
  logic [ByteW-1:0] dec_data;
  logic             dec_err;

  tmds_symbol_decode u_decode (
    .sym_i     (s1_sym_q),
    .is_ctrl_o (dec_is_ctrl),
    .ctrl_o    (dec_ctrl),
    .data_o    (dec_data),
    .err_o     (dec_err)
  );

  always_comb begin
    data_d     = dec_data;
    ctrl_d     = dec_ctrl;
    de_d       = !dec_is_ctrl;
    err_d      = s1_valid_q && dec_err;
    s2_valid_d = s1_valid_q;
  end

  always_comb begin
    state_d   = state_q;
    run_d     = run_q;
    srch_d    = srch_q;
    slip_d    = slip_q;
    errc_d    = errc_q;
    bitslip_d = 1'b0;
    unique case (state_q)
      SEARCH: begin
        if (s1_valid_q) begin
          srch_d = (srch_q == SrchMax) ? srch_q : srch_q + SrchW'(1);
          if (dec_is_ctrl) begin
            run_d = (run_q == RunMax) ? run_q : run_q + RunW'(1);
          end else begin
            run_d = '0;
          end
          // Lock wins over the search limit on the same symbol
          if (run_d == RunMax) begin
            state_d = LOCKED;
            run_d   = '0;
            srch_d  = '0;
            errc_d  = '0;
          end else if (srch_d == SrchMax) begin
            state_d   = SLIP;
            bitslip_d = 1'b1;
            run_d     = '0;
            srch_d    = '0;
            slip_d    = '0;
          end
        end
      end
      SLIP: begin
        // Timer runs every cycle; input is ignored while the deserializer settles
        slip_d = (slip_q == SlipMax) ? slip_q : slip_q + SlipW'(1);
        if (slip_d == SlipMax) begin
          state_d = SEARCH;
          run_d   = '0;
          srch_d  = '0;
          slip_d  = '0;
          errc_d  = '0;
        end
      end
      LOCKED: begin
        if (s1_valid_q) begin
          if (dec_is_ctrl) begin
            errc_d = '0;
          end else if (dec_err) begin
            errc_d = (errc_q == ErrMax) ? errc_q : errc_q + ErrW'(1);
          end
          if (errc_d == ErrMax) begin
            state_d = SEARCH;
            run_d   = '0;
            srch_d  = '0;
            errc_d  = '0;
          end
        end
      end
      default: state_d = SEARCH;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      s1_sym_q   <= '0;
      s1_valid_q <= 1'b0;
      data_q     <= '0;
      ctrl_q     <= '0;
      de_q       <= 1'b0;
      err_q      <= 1'b0;
      s2_valid_q <= 1'b0;
      state_q    <= SEARCH;
      run_q      <= '0;
      srch_q     <= '0;
      slip_q     <= '0;
      errc_q     <= '0;
      bitslip_q  <= 1'b0;
    end else begin
      s1_sym_q   <= sym_in;
      s1_valid_q <= sym_valid;
      data_q     <= data_d;
      ctrl_q     <= ctrl_d;
      de_q       <= de_d;
      err_q      <= err_d;
      s2_valid_q <= s2_valid_d;
      state_q    <= state_d;
      run_q      <= run_d;
      srch_q     <= srch_d;
      slip_q     <= slip_d;
      errc_q     <= errc_d;
      bitslip_q  <= bitslip_d;
    end
  end

  assign data_out  = data_q;
  assign ctrl_out  = ctrl_q;
  assign de_out    = de_q;
  assign err_out   = err_q;
  assign locked    = (state_q == LOCKED);
  assign out_valid = s2_valid_q && locked;
  assign bitslip   = bitslip_q;

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Self-checking bench for tmds_channel_decoder: directed stimulus, a reference
// model built from the encoder side, and a per-cycle compare process.
module tb_tmds_channel_decoder;

  localparam int LC = 8;
  localparam int SL = 64;
  localparam int SW = 4;
  localparam int EL = 4;

  localparam logic [9:0] T00 = 10'b1101010100;
  localparam logic [9:0] D00 = 10'b0100000000;
  localparam logic [9:0] DFF = 10'b1000000000;
  localparam logic [9:0] EFF = 10'b0101010101;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic [9:0] sym_in = '0;
  logic       sym_valid = 1'b0;
  logic [7:0] data_out;
  logic [1:0] ctrl_out;
  logic       de_out, out_valid, err_out, locked, bitslip;

  tmds_channel_decoder #(
    .LOCK_COUNT   (LC),
    .SEARCH_LIMIT (SL),
    .SLIP_WAIT    (SW),
    .ERR_LIMIT    (EL)
  ) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .sym_in    (sym_in),
    .sym_valid (sym_valid),
    .data_out  (data_out),
    .ctrl_out  (ctrl_out),
    .de_out    (de_out),
    .out_valid (out_valid),
    .err_out   (err_out),
    .locked    (locked),
    .bitslip   (bitslip)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  bit run_cmp = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (encoder-side view) ----------------
  // Encoder chain applied to a byte with a forced XOR (1) or XNOR (0) mode
  function automatic logic [7:0] enc_chain(input logic [7:0] b, input logic xor_mode);
    logic [7:0] q;
    q[0] = b[0];
    for (int i = 1; i < 8; i++) q[i] = xor_mode ? (q[i-1] ^ b[i]) : ~(q[i-1] ^ b[i]);
    return q;
  endfunction

  // Flag the encoder would choose: 1 = XOR, 0 = XNOR
  function automatic logic enc_flag(input logic [7:0] b);
    int n;
    n = $countones(b);
    return !((n > 4) || (n == 4 && b[0] == 1'b0));
  endfunction

  function automatic logic tok_of(input logic [9:0] s, output logic [1:0] c);
    c = 2'b00;
    if (s == 10'b1101010100) begin c = 2'b00; return 1'b1; end
    if (s == 10'b0010101011) begin c = 2'b01; return 1'b1; end
    if (s == 10'b0101010100) begin c = 2'b10; return 1'b1; end
    if (s == 10'b1010101011) begin c = 2'b11; return 1'b1; end
    return 1'b0;
  endfunction

  // Find the byte whose encoding under the symbol's flag gives this payload
  task automatic model_dec(input logic [9:0] s, output logic [7:0] b, output logic e);
    logic [7:0] d;
    d = s[9] ? ~s[7:0] : s[7:0];
    b = '0;
    for (int v = 0; v < 256; v++) begin
      if (enc_chain(8'(v), s[8]) == d) b = 8'(v);
    end
    e = (enc_flag(b) != s[8]);
  endtask

  localparam int MSEARCH = 0, MSLIP = 1, MLOCK = 2;

  logic       m_v1, m_s2v, m_de, m_err, m_slip;
  logic [9:0] m_s1;
  logic [7:0] m_data;
  logic [1:0] m_ctrl;
  int         m_mode, m_tok, m_seen, m_wait, m_errs;

  always @(posedge clk or negedge n_rst) begin : model
    int tok, seen, wt, errs, mode;
    logic slipp, isc, e;
    logic [7:0] b;
    logic [1:0] c;
    if (!n_rst) begin
      m_v1 <= 0; m_s1 <= '0; m_s2v <= 0; m_de <= 0; m_err <= 0; m_slip <= 0;
      m_data <= '0; m_ctrl <= '0;
      m_mode <= MSEARCH; m_tok <= 0; m_seen <= 0; m_wait <= 0; m_errs <= 0;
    end else begin
      tok = m_tok; seen = m_seen; wt = m_wait; errs = m_errs; mode = m_mode;
      slipp = 1'b0;
      isc = tok_of(m_s1, c);
      model_dec(m_s1, b, e);
      if (mode == MSLIP) begin
        wt++;
        if (wt >= SW) begin mode = MSEARCH; tok = 0; seen = 0; wt = 0; errs = 0; end
      end else if (m_v1) begin
        if (mode == MSEARCH) begin
          seen = (seen < SL) ? seen + 1 : SL;
          tok  = isc ? ((tok < LC) ? tok + 1 : LC) : 0;
          if (tok == LC) begin
            mode = MLOCK; tok = 0; seen = 0; errs = 0;
          end else if (seen == SL) begin
            mode = MSLIP; slipp = 1'b1; tok = 0; seen = 0; wt = 0;
          end
        end else begin
          if (isc) errs = 0;
          else if (e) errs = (errs < EL) ? errs + 1 : EL;
          if (errs == EL) begin mode = MSEARCH; errs = 0; tok = 0; seen = 0; end
        end
      end
      m_s2v  <= m_v1;
      m_de   <= !isc;
      m_data <= b;
      m_ctrl <= c;
      m_err  <= m_v1 && !isc && e;
      m_slip <= slipp;
      m_mode <= mode; m_tok <= tok; m_seen <= seen; m_wait <= wt; m_errs <= errs;
      m_v1   <= sym_valid;
      m_s1   <= sym_in;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (run_cmp && n_rst === 1'b1) begin
      chk("locked", locked, m_mode == MLOCK);
      chk("bitslip", bitslip, m_slip);
      chk("out_valid", out_valid, m_s2v && (m_mode == MLOCK));
      chk("err_out", err_out, m_err);
      if (m_s2v) begin
        chk("de_out", de_out, m_de);
        if (m_de) chk("data_out", data_out, m_data);
        else      chk("ctrl_out", ctrl_out, m_ctrl);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic send(input logic [9:0] s);
    @(negedge clk);
    sym_in = s;
    sym_valid = 1'b1;
  endtask

  // Bubble then wait one more cycle so the last symbol reaches the outputs
  task automatic flush();
    @(negedge clk);
    sym_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic relock_check(input string tag);
    repeat (LC - 1) send(T00);
    flush();
    chk({tag, "_not_yet"}, locked, 1'b0);
    send(T00);
    flush();
    chk({tag, "_locked"}, locked, 1'b1);
  endtask

  initial begin
    logic [7:0] pb;
    logic       pe;

    // Pin the model on hand-decoded symbols
    model_dec(EFF, pb, pe);
    chk("pin_eff_byte", pb, 8'hFF);
    chk("pin_eff_err", pe, 1'b1);
    model_dec(DFF, pb, pe);
    chk("pin_dff_byte", pb, 8'hFF);
    chk("pin_dff_err", pe, 1'b0);
    model_dec(D00, pb, pe);
    chk("pin_d00_byte", pb, 8'h00);
    chk("pin_d00_err", pe, 1'b0);

    repeat (2) @(negedge clk);
    chk("rst_data", data_out, 8'h00);
    chk("rst_ctrl", ctrl_out, 2'b00);
    chk("rst_de", de_out, 1'b0);
    chk("rst_ov", out_valid, 1'b0);
    chk("rst_err", err_out, 1'b0);
    chk("rst_locked", locked, 1'b0);
    chk("rst_bitslip", bitslip, 1'b0);
    n_rst = 1'b1;
    run_cmp = 1'b1;

    // Lock on eight tokens
    repeat (LC - 1) send(T00);
    flush();
    chk("lock_7_tokens", locked, 1'b0);
    send(T00);
    flush();
    chk("lock_locked", locked, 1'b1);
    chk("lock_ov", out_valid, 1'b1);
    chk("lock_de", de_out, 1'b0);
    chk("lock_ctrl", ctrl_out, 2'b00);

    // Clean data
    send(D00);
    flush();
    chk("d00_data", data_out, 8'h00);
    chk("d00_de", de_out, 1'b1);
    chk("d00_err", err_out, 1'b0);
    chk("d00_ov", out_valid, 1'b1);
    send(DFF);
    flush();
    chk("dff_data", data_out, 8'hFF);
    chk("dff_err", err_out, 1'b0);

    // Token after three errors clears the error count
    repeat (3) send(EFF);
    send(T00);
    repeat (3) send(EFF);
    flush();
    chk("err3_err", err_out, 1'b1);
    chk("err3_data", data_out, 8'hFF);
    chk("err3_locked", locked, 1'b1);
    // Fourth consecutive error drops lock, without a slip
    send(EFF);
    flush();
    chk("err4_err", err_out, 1'b1);
    chk("err4_locked", locked, 1'b0);
    chk("err4_ov", out_valid, 1'b0);
    chk("err4_noslip", bitslip, 1'b0);

    // Search limit -> bit slip
    @(negedge clk);
    n_rst = 1'b0;
    @(negedge clk);
    n_rst = 1'b1;
    repeat (SL - 1) send(D00);
    flush();
    chk("slip_63", bitslip, 1'b0);
    send(D00);
    @(negedge clk);
    sym_valid = 1'b0;
    @(negedge clk);
    chk("slip_pulse", bitslip, 1'b1);
    chk("slip_locked", locked, 1'b0);
    // Two tokens land inside the SLIP window and must be ignored
    send(T00);
    chk("slip_one_cycle", bitslip, 1'b0);
    send(T00);
    relock_check("after_slip");

    // Asynchronous reset with data in flight
    send(DFF);
    send(D00);
    @(posedge clk);
    #2;
    chk("pre_rst_de", de_out, 1'b1);
    chk("pre_rst_ov", out_valid, 1'b1);
    n_rst = 1'b0;
    #1;
    chk("mid_rst_data", data_out, 8'h00);
    chk("mid_rst_de", de_out, 1'b0);
    chk("mid_rst_ov", out_valid, 1'b0);
    chk("mid_rst_err", err_out, 1'b0);
    chk("mid_rst_locked", locked, 1'b0);
    chk("mid_rst_bitslip", bitslip, 1'b0);
    chk("mid_rst_ctrl", ctrl_out, 2'b00);
    @(negedge clk);
    sym_valid = 1'b0;
    n_rst = 1'b1;
    relock_check("after_rst");

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
